tm1638_display_ctrl: RTL and testbench

Frame sequencer for the TM1638 8-digit LED/key board. On a start request it snapshots eight BCD digits, eight LED bits and a brightness level. It runs each digit through the BCD-to-7-segment `translator`, bit-reverses the result into TM1638 segment order, and shifts the complete display image out over the TM1638 STB/CLK/DIO serial bus. It sits between the application's number/LED registers and the board pins, and it is the only driver of that bus.

---
 rtl/tm1638_display_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_tm1638_display_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_display_ctrl.sv
// -----------------------------------------------------------------------------
// tm1638_display_ctrl
//
// Frame sequencer for a TM1638 8-digit LED/key board. A start request
// snapshots eight BCD digits, eight LED bits and a brightness level. The block
// then shifts the whole display image out over the TM1638 STB/CLK/DIO bus:
//   CMD1  0x40                      (write data, auto-increment)
//   CMD2  0xC0, {seg0, led0} .. {seg7, led7}   (17 bytes under one STB low)
//   CMD3  0x88 | bright             (display on)
// Each command is followed by a gap with STB high for 2*CLK_DIV cycles.
// Bytes are sent LSB first. Each bit is CLK_DIV cycles with CLK low, then
// CLK_DIV cycles with CLK high.
//
// Optional feature: define TM1638_ZERO_BLANK_EN to send leading zero digits
// (digit 0 toward digit 6) as a blank segment byte.
//
// Ports
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   start   in   one-cycle frame request, sampled only while idle
//   digits  in   [31:0] BCD digits, digit k = digits[31-4k -: 4]
//   leds    in   [7:0] LED above digit k = leds[k]
//   bright  in   [2:0] PWM brightness
//   busy    out  frame in progress
//   done    out  one-cycle pulse at the end of a frame
//   tm_stb  out  TM1638 STB (active low)
//   tm_clk  out  TM1638 CLK
//   tm_dio  out  TM1638 DIO (always driven)
// -----------------------------------------------------------------------------

// BCD to 7-segment, o_seg[7]=a .. o_seg[1]=g, o_seg[0]=dp.
// Non-BCD input lights the decimal point only.
module translator (
  input  logic [3:0] i_bcd,
  output logic [7:0] o_seg
);
  always_comb begin
    o_seg = 8'h01;
    case (i_bcd)
      4'd0:    o_seg = 8'hFC;
      4'd1:    o_seg = 8'h60;
      4'd2:    o_seg = 8'hDA;
      4'd3:    o_seg = 8'hF2;
      4'd4:    o_seg = 8'h66;
      4'd5:    o_seg = 8'hB6;
      4'd6:    o_seg = 8'hBE;
      4'd7:    o_seg = 8'hE0;
      4'd8:    o_seg = 8'hFE;
      4'd9:    o_seg = 8'hF6;
      default: o_seg = 8'h01;
    endcase
  end
endmodule

module tm1638_display_ctrl #(
  parameter int CLK_DIV = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] digits,
  input  logic [7:0]  leds,
  input  logic [2:0]  bright,
  output logic        busy,
  output logic        done,
  output logic        tm_stb,
  output logic        tm_clk,
  output logic        tm_dio
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD1, S_GAP1, S_CMD2, S_GAP2, S_CMD3, S_GAP3
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [HW-1:0]  r_half;
  logic           r_phase;   // 0: CLK low half, 1: CLK high half
  logic [2:0]     r_bit;
  logic [4:0]     r_byte;
  logic           r_tail;    // final cycle of GAP3, where done is issued

  logic [31:0]    r_digits;
  logic [7:0]     r_leds;
  logic [2:0]     r_bright;

  logic           r_busy, r_done, r_stb, r_clk, r_dio;
  logic           w_busy_nxt, w_done_nxt, w_stb_nxt, w_clk_nxt, w_dio_nxt;

  logic           w_last_half, w_bit_end, w_byte_end;
  logic [2:0]     w_seg_idx, w_led_idx;
  logic [3:0]     w_nibble;
  logic [7:0]     w_seg_raw, w_seg_tm;
  logic           w_blank;
  logic [7:0]     w_tx_byte;

  assign busy   = r_busy;
  assign done   = r_done;
  assign tm_stb = r_stb;
  assign tm_clk = r_clk;
  assign tm_dio = r_dio;

  assign w_last_half = (r_half == H_LAST);
  assign w_bit_end   = w_last_half && r_phase;
  assign w_byte_end  = w_bit_end && (r_bit == 3'd7);

  // CMD2 byte n: odd n carries the segment byte of digit (n-1)/2,
  // even n >= 2 carries the LED byte of digit n/2-1.
  assign w_seg_idx = r_byte[3:1];
  assign w_led_idx = r_byte[3:1] - 3'd1;
  assign w_nibble  = r_digits[{~w_seg_idx, 2'b00} +: 4];

  translator u_translator (
    .i_bcd (w_nibble),
    .o_seg (w_seg_raw)
  );

  // TM1638 wants segment a in bit 0, so the translator output is reversed.
  always_comb begin
    w_seg_tm = 8'h00;
    for (int i = 0; i < 8; i++) begin
      w_seg_tm[i] = w_seg_raw[7-i];
    end
  end

`ifdef TM1638_ZERO_BLANK_EN
  logic [7:0] w_lead;

  // w_lead[k]: digits 0..k are all zero.
  always_comb begin
    logic run;
    run    = 1'b1;
    w_lead = 8'h00;
    for (int k = 0; k < 8; k++) begin
      run       = run && (r_digits[(7-k)*4 +: 4] == 4'd0);
      w_lead[k] = run;
    end
  end

  assign w_blank = w_lead[w_seg_idx] && (w_seg_idx != 3'd7);
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    w_tx_byte = 8'h00;
    case (r_state)
      S_CMD1: w_tx_byte = 8'h40;
      S_CMD3: w_tx_byte = {5'b10001, r_bright};
      S_CMD2: begin
        if (r_byte == 5'd0)
          w_tx_byte = 8'hC0;
        else if (r_byte[0])
          w_tx_byte = w_blank ? 8'h00 : w_seg_tm;
        else
          w_tx_byte = {7'd0, r_leds[w_led_idx]};
      end
      default: w_tx_byte = 8'h00;
    endcase
  end

  // Next state and next bus values. Bus outputs are registered, so the
  // pins follow the state with one cycle of latency.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_stb_nxt   = 1'b1;
    w_clk_nxt   = 1'b1;
    w_dio_nxt   = 1'b1;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_CMD1;
      S_CMD1: if (w_byte_end) w_state_nxt = S_GAP1;
      S_GAP1: if (w_bit_end) w_state_nxt = S_CMD2;
      S_CMD2: if (w_byte_end && (r_byte == 5'd16)) w_state_nxt = S_GAP2;
      S_GAP2: if (w_bit_end) w_state_nxt = S_CMD3;
      S_CMD3: if (w_byte_end) w_state_nxt = S_GAP3;
      S_GAP3: begin
        if (r_tail) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if ((r_state == S_CMD1) || (r_state == S_CMD2) || (r_state == S_CMD3)) begin
      w_stb_nxt = 1'b0;
      w_clk_nxt = r_phase;
      w_dio_nxt = w_tx_byte[r_bit];
    end
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Bit timing counters; cleared on every state change so each state
  // starts its own count from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_half  <= '0;
      r_phase <= 1'b0;
      r_bit   <= 3'd0;
      r_byte  <= 5'd0;
      r_tail  <= 1'b0;
    end else if (w_state_nxt != r_state) begin
      r_half  <= '0;
      r_phase <= 1'b0;
      r_bit   <= 3'd0;
      r_byte  <= 5'd0;
      r_tail  <= 1'b0;
    end else if (r_state != S_IDLE) begin
      r_half <= w_last_half ? '0 : r_half + HW'(1);
      if (w_last_half) r_phase <= ~r_phase;
      if (w_bit_end)   r_bit   <= r_bit + 3'd1;
      if (w_byte_end)  r_byte  <= r_byte + 5'd1;
      if ((r_state == S_GAP3) && w_bit_end) r_tail <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_stb  <= 1'b1;
      r_clk  <= 1'b1;
      r_dio  <= 1'b1;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_stb  <= w_stb_nxt;
      r_clk  <= w_clk_nxt;
      r_dio  <= w_dio_nxt;
    end
  end

  // Input snapshot on the accepting edge
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && start) begin
      r_digits <= digits;
      r_leds   <= leds;
      r_bright <= bright;
    end
  end

endmodule

// File: tb/tb_tm1638_display_ctrl.sv
// Scoreboard bench for tm1638_display_ctrl. Stimulus pushes hand-computed
// byte streams and done edges into queues; a monitor decodes the serial bus
// and pops/compares as bytes and done pulses appear.
module tb_tm1638_display_ctrl;
  localparam int CLK_DIV = 2;
  localparam int FRAME   = 310 * CLK_DIV;

`ifdef TM1638_ZERO_BLANK_EN
  localparam logic [7:0] Z0 = 8'h00;
`else
  localparam logic [7:0] Z0 = 8'h3F;
`endif

  localparam logic [151:0] V_FULL = {8'h40, 8'hC0, Z0, 8'h01, 8'h06, 8'h00, 8'h5B, 8'h01,
                                     8'h4F, 8'h00, 8'h66, 8'h00, 8'h6D, 8'h01, 8'h7D, 8'h00,
                                     8'h07, 8'h01, 8'h8F};
  localparam logic [151:0] V_INV  = {8'h40, 8'hC0, 8'h80, 8'h00, 8'h3F, 8'h00, 8'h3F, 8'h00,
                                     8'h3F, 8'h00, 8'h3F, 8'h00, 8'h3F, 8'h00, 8'h3F, 8'h00,
                                     8'h6F, 8'h00, 8'h88};
  localparam logic [151:0] V_SNAP = {8'h40, 8'hC0, Z0, 8'h00, 8'h06, 8'h00, 8'h5B, 8'h01,
                                     8'h4F, 8'h01, 8'h66, 8'h01, 8'h6D, 8'h01, 8'h7D, 8'h00,
                                     8'h07, 8'h00, 8'h8B};
`ifdef TM1638_ZERO_BLANK_EN
  localparam logic [151:0] V_ZB1  = {8'h40, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                     8'h66, 8'h00, 8'h3F, 8'h00, 8'h3F, 8'h00, 8'h3F, 8'h00,
                                     8'h3F, 8'h00, 8'h88};
  localparam logic [151:0] V_ZB0  = {8'h40, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                     8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                     8'h3F, 8'h00, 8'h88};
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] digits = 32'd0;
  logic [7:0]  leds = 8'd0;
  logic [2:0]  bright = 3'd0;
  logic        busy, done, tm_stb, tm_clk, tm_dio;

  tm1638_display_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .digits (digits),
    .leds   (leds),
    .bright (bright),
    .busy   (busy),
    .done   (done),
    .tm_stb (tm_stb),
    .tm_clk (tm_clk),
    .tm_dio (tm_dio)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic [7:0]  exp_q[$];
  int unsigned done_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus and done monitor, sampling on the falling system clock edge
  initial begin
    logic       p_clk, p_stb, p_dio;
    logic [7:0] sh;
    int         nb;
    p_clk = 1'b1; p_stb = 1'b1; p_dio = 1'b1; sh = 8'h00; nb = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        nb = 0;
      end else begin
        if (!tm_stb && tm_clk && !p_clk) begin
          chk("dio_setup", {31'd0, tm_dio}, {31'd0, p_dio});
          sh[nb] = tm_dio;
          nb++;
          if (nb == 8) begin
            nb = 0;
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL byte: got %02h expected none (cycle %0d)", sh, cyc);
            end else begin
              chk("byte", {24'd0, sh}, {24'd0, exp_q.pop_front()});
            end
          end
        end
        if (tm_stb && !p_stb) chk("stb_align", nb, 0);
        if (done) begin
          if (done_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL done: got pulse at cycle %0d expected none", cyc);
          end else begin
            chk("done_edge", cyc, done_q.pop_front());
          end
          chk("busy_at_done", {31'd0, busy}, 32'd0);
        end
      end
      p_clk = tm_clk; p_stb = tm_stb; p_dio = tm_dio;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] d, input logic [7:0] l, input logic [2:0] b,
                          input logic [151:0] v, input int n, output int unsigned acc);
    digits = d; leds = l; bright = b; start = 1'b1;
    for (int i = 0; i < n; i++) exp_q.push_back(v[151-8*i -: 8]);
    tick();
    start = 1'b0;
    acc = cyc;
    done_q.push_back(acc + 1 + FRAME);
    chk("busy_rise", {31'd0, busy}, 32'd1);
    chk("stb_before_edge1", {31'd0, tm_stb}, 32'd1);
    tick();
    chk("stb_edge1", {31'd0, tm_stb}, 32'd0);
  endtask

  task automatic wait_frame();
    for (int i = 0; i < FRAME + 20; i++) begin
      if (done_q.size() == 0) break;
      tick();
    end
    if (done_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL frame_timeout: got no done expected done by cycle %0d", done_q[0]);
      done_q.delete();
    end
    chk("bytes_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int unsigned a;
    tick(); tick();
    chk("rst_stb", {31'd0, tm_stb}, 32'd1);
    chk("rst_clk", {31'd0, tm_clk}, 32'd1);
    chk("rst_dio", {31'd0, tm_dio}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    tick(); tick();

    // Full frame
    do_start(32'h01234567, 8'hA5, 3'd7, V_FULL, 19, a);
    wait_frame();
    tick(); tick();

    // Non-BCD digit
    do_start(32'hF0000009, 8'h00, 3'd0, V_INV, 19, a);
    wait_frame();
    tick();

    // Start while busy is ignored
    do_start(32'h01234567, 8'hA5, 3'd7, V_FULL, 19, a);
    while (cyc < a + 100) tick();
    digits = 32'h88888888; start = 1'b1;
    tick();
    start = 1'b0;
    wait_frame();
    for (int i = 0; i < FRAME + 40; i++) tick();
    chk("busy_after_ignored", {31'd0, busy}, 32'd0);

    // Input snapshot: inputs change one cycle after the accepting edge
    do_start(32'h01234567, 8'h3C, 3'd3, V_SNAP, 19, a);
    digits = 32'h88888888; leds = 8'hFF; bright = 3'd0;
    wait_frame();
    tick();

    // Reset during CMD2 byte 5
    do_start(32'h01234567, 8'hA5, 3'd7, V_FULL, 6, a);
    while (cyc < a + 205) tick();
    rst = 1'b1;
    #1;
    chk("abort_stb", {31'd0, tm_stb}, 32'd1);
    chk("abort_clk", {31'd0, tm_clk}, 32'd1);
    chk("abort_dio", {31'd0, tm_dio}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_bytes_seen", exp_q.size(), 0);
    done_q.delete();
    exp_q.delete();
    tick(); tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    do_start(32'h01234567, 8'hA5, 3'd7, V_FULL, 19, a);
    wait_frame();
    tick();

`ifdef TM1638_ZERO_BLANK_EN
    do_start(32'h00040000, 8'h00, 3'd0, V_ZB1, 19, a);
    wait_frame();
    tick();
    do_start(32'h00000000, 8'h00, 3'd0, V_ZB0, 19, a);
    wait_frame();
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
